// File: rtl/intr_timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the machine-level interrupt/timer block:
//   - FSM state encoding (legacy localparam constants plus a typed enum)
//   - register word offsets inside the 32-byte window
//   - interrupt cause codes handed to the CSR file
//   - cause_of(): maps an FSM state to the cause code it presents
// -----------------------------------------------------------------------------
package intr_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ_EXT = 2'd1;
    localparam logic [1:0] ST_REQ_TMR = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        REQ_EXT = ST_REQ_EXT,
        REQ_TMR = ST_REQ_TMR
    } intr_state_e;

    localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_CTRL        = 5'h10;
    localparam logic [4:0] OFF_PEND        = 5'h14;

    localparam logic [3:0] INTR_NONE  = 4'd0;
    localparam logic [3:0] INTR_TIMER = 4'd1;
    localparam logic [3:0] INTR_EXT   = 4'd2;

    function automatic logic [3:0] cause_of(input intr_state_e st);
        logic [3:0] code;
        case (st)
            IDLE:    code = INTR_NONE;
            REQ_TMR: code = INTR_TIMER;
            REQ_EXT: code = INTR_EXT;
            default: code = INTR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/intr_timer_ctrl_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchroniser for an asynchronous level, plus one history flop so a
// single-cycle pulse marks each rising edge of the synchronised level.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset
//   async_in - asynchronous input level
//   rise     - one-cycle pulse on a rising edge of the synchronised level
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic sync_d_r;

    // synchroniser chain plus one cycle of history of the synchronised level
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            sync_d_r <= 1'b0;
        end else begin
            meta_r   <= async_in;
            sync_r   <= meta_r;
            sync_d_r <= sync_r;
        end
    end

    assign rise = sync_r & ~sync_d_r;

endmodule

// File: rtl/intr_timer_ctrl.sv
// -----------------------------------------------------------------------------
// intr_timer_ctrl
// Machine-level interrupt source: memory-mapped 64-bit mtime/mtimecmp timer,
// a synchronised external interrupt line, and an arbiter that holds a cause
// code for the CSR file until the trap is acknowledged.
// Parameters:
//   PRESCALE  - clk cycles per mtime tick (1..65535)
//   BASE_ADDR - byte base of the 32-byte register window
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   addr/wdata      - data-bus address and store data
//   wr_en/rd_en     - store / load strobes
//   rdata           - load data (combinational from addr)
//   sel             - addr falls in the register window
//   ext_irq         - asynchronous external interrupt, active-high
//   irq_ack         - pulse: interrupt trap taken
//   interrupt       - cause code (0 none, 1 timer, 2 external)
// -----------------------------------------------------------------------------
module intr_timer_ctrl
    import intr_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        sel,
    input  logic        ext_irq,
    input  logic        irq_ack,
    output logic [3:0]  interrupt
);

    localparam logic [15:0] PRESCALE_M1 = 16'(PRESCALE - 1);

    logic [15:0] presc_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        ten_r;
    logic        een_r;
    logic        cmp_q_r;
    logic        tp_r;
    logic        ep_r;
    intr_state_e state_r;
    intr_state_e state_nxt_s;
    logic [3:0]  interrupt_r;
    logic [31:0] rdata_s;

    logic        sel_s;
    logic [4:0]  offset_s;
    logic        wr_s;
    logic        tick_s;
    logic        cmp_s;
    logic        tp_set_s;
    logic        ep_set_s;
    logic        ext_rise_s;
    logic        ack_tmr_s;
    logic        ack_ext_s;

    assign sel_s    = (addr[31:5] == BASE_ADDR[31:5]);
    assign offset_s = addr[4:0];
    assign wr_s     = wr_en & sel_s;
    assign sel      = sel_s;

    sync_edge_det u_ext_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ext_irq),
        .rise     (ext_rise_s)
    );

    // prescaler: counts while TEN is set and holds its phase otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_r <= 16'd0;
        end else if (ten_r) begin
            if (presc_r == PRESCALE_M1) begin
                presc_r <= 16'd0;
            end else begin
                presc_r <= presc_r + 16'd1;
            end
        end else begin
            presc_r <= presc_r;
        end
    end

    assign tick_s = ten_r & (presc_r == PRESCALE_M1);

    // mtime: a CPU write to either half wins over a coincident tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_r <= 64'd0;
        end else if (wr_s && (offset_s == OFF_MTIME_LO)) begin
            mtime_r[31:0] <= wdata;
        end else if (wr_s && (offset_s == OFF_MTIME_HI)) begin
            mtime_r[63:32] <= wdata;
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
        end else begin
            mtime_r <= mtime_r;
        end
    end

    // mtimecmp and ctrl registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            ten_r      <= 1'b0;
            een_r      <= 1'b0;
        end else begin
            if (wr_s && (offset_s == OFF_MTIMECMP_LO)) begin
                mtimecmp_r[31:0] <= wdata;
            end else if (wr_s && (offset_s == OFF_MTIMECMP_HI)) begin
                mtimecmp_r[63:32] <= wdata;
            end else begin
                mtimecmp_r <= mtimecmp_r;
            end
            if (wr_s && (offset_s == OFF_CTRL)) begin
                ten_r <= wdata[0];
                een_r <= wdata[1];
            end else begin
                ten_r <= ten_r;
                een_r <= een_r;
            end
        end
    end

    assign cmp_s     = (mtime_r >= mtimecmp_r);
    assign tp_set_s  = cmp_s & ~cmp_q_r & ten_r;
    assign ep_set_s  = ext_rise_s & een_r;
    assign ack_tmr_s = irq_ack & (state_r == REQ_TMR);
    assign ack_ext_s = irq_ack & (state_r == REQ_EXT);

    // pending bits: a new set beats a coincident acknowledge
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmp_q_r <= 1'b0;
            tp_r    <= 1'b0;
            ep_r    <= 1'b0;
        end else begin
            cmp_q_r <= cmp_s;
            tp_r    <= tp_set_s | (tp_r & ~ack_tmr_s);
            ep_r    <= ep_set_s | (ep_r & ~ack_ext_s);
        end
    end

    // arbiter: only IDLE arbitrates, external first; a request holds until acked
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ep_r) begin
                    state_nxt_s = REQ_EXT;
                end else if (tp_r) begin
                    state_nxt_s = REQ_TMR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ_EXT: begin
                if (irq_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REQ_EXT;
                end
            end
            REQ_TMR: begin
                if (irq_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REQ_TMR;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // state register; the cause code is registered alongside from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            interrupt_r <= INTR_NONE;
        end else begin
            state_r     <= state_nxt_s;
            interrupt_r <= cause_of(state_nxt_s);
        end
    end

    assign interrupt = interrupt_r;

    // read mux: zero unless a load hits the window
    always_comb begin
        rdata_s = 32'd0;
        if (rd_en && sel_s) begin
            case (offset_s)
                OFF_MTIME_LO:    rdata_s = mtime_r[31:0];
                OFF_MTIME_HI:    rdata_s = mtime_r[63:32];
                OFF_MTIMECMP_LO: rdata_s = mtimecmp_r[31:0];
                OFF_MTIMECMP_HI: rdata_s = mtimecmp_r[63:32];
                OFF_CTRL:        rdata_s = {30'd0, een_r, ten_r};
                OFF_PEND:        rdata_s = {30'd0, ep_r, tp_r};
                default:         rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign rdata = rdata_s;

endmodule

// File: tb/tb_intr_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_timer_ctrl
// Directed scenarios followed by randomized bus/ext_irq/irq_ack/rst traffic.
// A behavioural model (cause code, pending flags, 64-bit counters and a
// cycle-count prescaler) runs alongside; one negedge process compares
// interrupt, rdata and sel against it every cycle, and the directed parts
// add literal expectations for latencies and register values.
// -----------------------------------------------------------------------------
module tb_intr_timer_ctrl;

    localparam int unsigned PS   = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        sel;
    logic        ext_irq;
    logic        irq_ack;
    logic [3:0]  interrupt;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    intr_timer_ctrl #(.PRESCALE(PS), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .rdata     (rdata),
        .sel       (sel),
        .ext_irq   (ext_irq),
        .irq_ack   (irq_ack),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime, m_cmpv;
    logic        m_ten, m_een, m_tp, m_ep, m_cmpq;
    logic [2:0]  m_hist;      // [0] newest sample of ext_irq
    int unsigned m_encyc;     // clk cycles spent with TEN=1
    logic [3:0]  m_int;       // cause code currently presented

    always @(posedge clk) begin : model
        logic cmp_now, tick, tp_set, ep_set, w;
        logic [4:0] off;
        if (!rst) begin
            m_mtime = 64'd0; m_cmpv = 64'hFFFF_FFFF_FFFF_FFFF;
            m_ten = 1'b0; m_een = 1'b0; m_tp = 1'b0; m_ep = 1'b0;
            m_cmpq = 1'b0; m_hist = 3'b000; m_encyc = 0; m_int = 4'd0;
        end else begin
            cmp_now = (m_mtime >= m_cmpv);
            tick    = m_ten && ((m_encyc % PS) == (PS - 1));
            tp_set  = cmp_now && !m_cmpq && m_ten;
            ep_set  = m_hist[1] && !m_hist[2] && m_een;
            if (m_int == 4'd0) begin
                m_int = m_ep ? 4'd2 : (m_tp ? 4'd1 : 4'd0);
            end else if (irq_ack) begin
                if (m_int == 4'd1) m_tp = 1'b0;
                else m_ep = 1'b0;
                m_int = 4'd0;
            end
            if (tp_set) m_tp = 1'b1;
            if (ep_set) m_ep = 1'b1;
            w   = wr_en && (addr[31:5] == BASE[31:5]);
            off = addr[4:0];
            if (w && off == 5'h00)      m_mtime[31:0]  = wdata;
            else if (w && off == 5'h04) m_mtime[63:32] = wdata;
            else if (tick)              m_mtime        = m_mtime + 64'd1;
            if (w && off == 5'h08) m_cmpv[31:0]  = wdata;
            if (w && off == 5'h0C) m_cmpv[63:32] = wdata;
            if (m_ten) m_encyc = m_encyc + 1;
            if (w && off == 5'h10) begin
                m_ten = wdata[0];
                m_een = wdata[1];
            end
            m_cmpq = cmp_now;
            m_hist = {m_hist[1:0], ext_irq};
        end
    end

    function automatic logic [31:0] m_rdata();
        if (!rd_en || (addr[31:5] != BASE[31:5])) return 32'd0;
        case (addr[4:0])
            5'h00:   return m_mtime[31:0];
            5'h04:   return m_mtime[63:32];
            5'h08:   return m_cmpv[31:0];
            5'h0C:   return m_cmpv[63:32];
            5'h10:   return {30'd0, m_een, m_ten};
            5'h14:   return {30'd0, m_ep, m_tp};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("interrupt", {60'd0, interrupt}, {60'd0, m_int});
            chk("rdata", {32'd0, rdata}, {32'd0, m_rdata()});
            chk("sel", {63'd0, sel}, {63'd0, (addr[31:5] == BASE[31:5])});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
        addr = BASE + {27'd0, off}; wdata = d; wr_en = 1'b1; rd_en = 1'b0;
        tick_clk();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
        addr = BASE + {27'd0, off}; rd_en = 1'b1; wr_en = 1'b0;
        #2;
        d = rdata;
        tick_clk();
        rd_en = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick_clk();
        irq_ack = 1'b0;
    endtask

    task automatic wait_int(input logic [3:0] code, input int budget, input string name, output int n);
        n = 0;
        while ((interrupt !== code) && (n < budget)) begin
            tick_clk();
            n++;
        end
        chk(name, {60'd0, interrupt}, {60'd0, code});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int n;
        logic found;
        clk = 1'b0; rst = 1'b0; addr = BASE; wdata = 32'd0;
        wr_en = 1'b0; rd_en = 1'b0; ext_irq = 1'b0; irq_ack = 1'b0;

        // reset
        tick_clk(); tick_clk();
        rst = 1'b1; chk_en = 1'b1;
        bus_read(5'h08, d); chk("rst mtimecmp_lo", {32'd0, d}, 64'hFFFF_FFFF);
        bus_read(5'h0C, d); chk("rst mtimecmp_hi", {32'd0, d}, 64'hFFFF_FFFF);
        bus_read(5'h14, d); chk("rst pend", {32'd0, d}, 64'd0);
        chk("rst interrupt", {60'd0, interrupt}, 64'd0);
        chk("rst model int", {60'd0, m_int}, 64'd0);

        // timer fire at mtime=10 with PRESCALE=4
        bus_write(5'h08, 32'd10);
        bus_write(5'h0C, 32'd0);
        bus_write(5'h10, 32'd1);
        wait_int(4'd1, 60, "timer fire", n);
        chk("timer latency", n, 64'd42);
        bus_read(5'h00, d); chk("mtime at fire", {32'd0, d}, 64'd10);
        ack();
        chk("timer ack clears", {60'd0, interrupt}, 64'd0);
        repeat (20) tick_clk();
        chk("timer no refire", {60'd0, interrupt}, 64'd0);

        // external
        bus_write(5'h10, 32'd2);
        ext_irq = 1'b1;
        tick_clk();
        wait_int(4'd2, 10, "ext fire", n);
        chk("ext latency", n, 64'd3);
        ack();
        chk("ext ack clears", {60'd0, interrupt}, 64'd0);
        repeat (10) tick_clk();
        chk("ext held no refire", {60'd0, interrupt}, 64'd0);
        ext_irq = 1'b0;
        repeat (3) tick_clk();
        ext_irq = 1'b1;
        wait_int(4'd2, 8, "ext second edge", n);
        ack();
        ext_irq = 1'b0;
        repeat (4) tick_clk();

        // priority: tp and ep set on the same edge
        bus_write(5'h0C, 32'd1);
        bus_write(5'h10, 32'd3);
        ext_irq = 1'b1;
        tick_clk();
        bus_write(5'h0C, 32'd0);
        wait_int(4'd2, 6, "prio ext first", n);
        chk("prio latency", n, 64'd2);
        bus_read(5'h14, d); chk("prio both pending", {32'd0, d}, 64'd3);
        ack();
        tick_clk();
        chk("prio timer next", {60'd0, interrupt}, 64'd1);
        ack();
        chk("prio timer ack", {60'd0, interrupt}, 64'd0);
        ext_irq = 1'b0;

        // wrap and write/tick race
        bus_write(5'h10, 32'd0);
        bus_write(5'h0C, 32'hFFFF_FFFF);
        bus_write(5'h00, 32'hFFFF_FFFF);
        bus_write(5'h04, 32'hFFFF_FFFF);
        bus_write(5'h10, 32'd1);
        addr = BASE; rd_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            tick_clk();
            if (rdata == 32'd0) found = 1'b1;
        end
        rd_en = 1'b0;
        chk("wrap lo to zero", {63'd0, found}, 64'd1);
        bus_read(5'h04, d); chk("wrap hi zero", {32'd0, d}, 64'd0);
        n = 0;
        while (!(m_ten && ((m_encyc % PS) == (PS - 1))) && n < 8) begin
            tick_clk();
            n++;
        end
        bus_write(5'h00, 32'd5);
        bus_read(5'h00, d); chk("write beats tick", {32'd0, d}, 64'd5);

        // reset in the middle of a timer request
        bus_write(5'h08, 32'd0);
        bus_write(5'h0C, 32'd0);
        wait_int(4'd1, 6, "tmr request", n);
        chk("tmr latency", n, 64'd2);
        rst = 1'b0;
        tick_clk();
        rst = 1'b1;
        chk("reset mid int", {60'd0, interrupt}, 64'd0);
        bus_read(5'h14, d); chk("reset mid pend", {32'd0, d}, 64'd0);
        bus_read(5'h00, d); chk("reset mid mtime", {32'd0, d}, 64'd0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [4:0] off;
            off = 5'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 15) == 0) off = 5'($urandom_range(0, 31));
            addr = BASE + {27'd0, off};
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            rd_en = 1'($urandom_range(0, 1));
            wr_en = ($urandom_range(0, 99) < 12);
            case (off)
                5'h00, 5'h08: wdata = ($urandom_range(0, 7) == 0) ? $urandom
                                      : m_mtime[31:0] + 32'($urandom_range(0, 40));
                5'h04, 5'h0C: wdata = ($urandom_range(0, 15) == 0) ? $urandom
                                      : m_mtime[63:32] + 32'($urandom_range(0, 1));
                default:      wdata = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
            irq_ack = (m_int != 4'd0) && ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 399) != 0);
            tick_clk();
        end
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; irq_ack = 1'b0;
        repeat (5) tick_clk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
